// File: rtl/simple_pipe_n.sv
// simple_pipe_n: half-split bitwise function carried through a STAGES-deep
// valid/ready pipeline with bubble collapsing, occupancy count and synchronous flush.
`timescale 1ns/1ps
module simple_pipe_n #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  localparam int CW    = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic [1:0]    in_op,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic [CW-1:0] occupancy
);

  localparam int H = W / 2;

  function automatic logic [W-1:0] half_fn(input logic [W-1:0] x, input logic [1:0] op);
    logic [H-1:0] hi;
    logic [H-1:0] lo;
    logic [W-1:0] r;
    hi = x[W-1:H];
    lo = x[H-1:0];
    case (op)
      2'd0:    r = {hi ^ lo, hi & lo};
      2'd1:    r = {hi ^ lo, hi | lo};
      2'd2:    r = {hi & lo, hi ^ lo};
      default: r = x;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] v_r;
  logic [W-1:0]      d_r [STAGES];
  logic [CW-1:0]     occ_r;

  logic [STAGES:0]   rdy_s;
  logic [STAGES-1:0] vin_s;
  logic [W-1:0]      din_s [STAGES];
  logic              in_fire_s;
  logic              out_fire_s;
  logic              all_v_s;

  // Ready chain (stage k stalls only if it and every later stage is full
  // with the consumer stalled) plus each stage's upstream source.
  always_comb begin
    rdy_s         = '0;
    all_v_s       = 1'b1;
    rdy_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_v_s  = all_v_s & v_r[k];
      rdy_s[k] = !all_v_s || out_ready;
    end
    vin_s[0] = in_valid;
    din_s[0] = half_fn(in_data, in_op);
    for (int k = 1; k < STAGES; k++) begin
      vin_s[k] = v_r[k-1];
      din_s[k] = d_r[k-1];
    end
  end

  assign in_ready   = rdy_s[0];
  assign in_fire_s  = in_valid && rdy_s[0];
  assign out_fire_s = v_r[STAGES-1] && out_ready;

  // Stage registers: reset clears everything, flush drops valids, otherwise ready-gated shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_r[k] <= '0;
      end
    end else if (flush) begin
      v_r <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy_s[k]) begin
          v_r[k] <= vin_s[k];
          if (vin_s[k]) begin
            d_r[k] <= din_s[k];
          end
        end
      end
    end
  end

  // Occupancy tracks accepted minus delivered items; flush empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else if (flush) begin
      occ_r <= '0;
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign out_data  = d_r[STAGES-1];
  assign occupancy = occ_r;

endmodule
